// File: rtl/demux1hot_pkg.sv
// demux1hot_pkg: one-hot select helpers shared by the demux and the one-hot mux benches.
// Selects up to 32 bits wide; callers zero-extend narrower selects.
package demux1hot_pkg;
  function automatic bit is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) if (v[i]) idx = 5'(i);
    return idx;
  endfunction
endpackage

// File: rtl/demux1hot_slot.sv
// demux1hot_slot: one-entry register slice; a load wins over a drain in the same cycle.
module demux1hot_slot #(
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else begin
      if (ld) q <= d;
      vld <= ld | (vld & ~rdy);
    end
  end
endmodule

// File: rtl/demux1hot_stream.sv
// demux1hot_stream: one-hot stream demultiplexer with a register slot per output.
// Define DEMUX1HOT_ERR_CNT_EN to add the saturating err_cnt of dropped illegal-select beats.
module demux1hot_stream
  import demux1hot_pkg::*;
#(
  parameter int OUTPUTS = 4,
  parameter int WIDTH   = 8
`ifdef DEMUX1HOT_ERR_CNT_EN
  , parameter int CNT_W = 16
`endif
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [OUTPUTS-1:0]       in_sel,
  output logic [OUTPUTS-1:0]       out_valid,
  input  logic [OUTPUTS-1:0]       out_ready,
  output logic [WIDTH*OUTPUTS-1:0] out_data,
  output logic                     err_illegal_sel
`ifdef DEMUX1HOT_ERR_CNT_EN
  , output logic [CNT_W-1:0]       err_cnt
`endif
);
  logic [OUTPUTS-1:0] free, load;
  logic legal;
  always_comb begin
    free     = ~out_valid | out_ready;
    legal    = is_onehot(32'(in_sel));
    in_ready = !in_valid ? |free : legal ? |(in_sel & free) : 1'b1;
    load     = (in_valid && legal) ? (in_sel & free) : '0;
  end
  for (genvar k = 0; k < OUTPUTS; k++) begin : g_slot
    demux1hot_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (load[k]),
      .d    (in_data),
      .rdy  (out_ready[k]),
      .vld  (out_valid[k]),
      .q    (out_data[k*WIDTH +: WIDTH])
    );
  end
  // Illegal beats are always consumed, so in_valid alone marks the drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_illegal_sel <= 1'b0;
    else        err_illegal_sel <= in_valid & ~legal;
  end
`ifdef DEMUX1HOT_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_cnt <= '0;
    else if (in_valid && !legal && ~&err_cnt)  err_cnt <= err_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_demux1hot_stream.sv
// tb_demux1hot_stream: directed + soak stimulus; a negedge monitor checks per-port order,
// stall stability and error pulses against queues filled by the driver.
module tb_demux1hot_stream;
  localparam int N = 4;
  localparam int W = 8;
`ifdef DEMUX1HOT_ERR_CNT_EN
  localparam int CW = 4;
  logic [CW-1:0] err_cnt;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [N-1:0] in_sel = '0, out_ready = '0;
  logic in_ready, err_illegal_sel;
  logic [N-1:0] out_valid;
  logic [N*W-1:0] out_data;
  int n_cmp = 0, n_fail = 0;
  logic [W-1:0] q[N][$];
  logic [N-1:0] stall = '0;
  logic [W-1:0] pd[N];
  bit exp_err = 1'b0;

  demux1hot_stream #(
    .OUTPUTS(N), .WIDTH(W)
`ifdef DEMUX1HOT_ERR_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_illegal_sel(err_illegal_sel)
`ifdef DEMUX1HOT_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sel_idx(input logic [N-1:0] s);
    int r = 0;
    for (int i = 0; i < N; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic logic [W-1:0] slot(input int k);
    return out_data[k*W +: W];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N-1:0] s, input logic [W-1:0] d);
    in_valid = 1'b1; in_sel = s; in_data = d;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i == 50) begin
        check("send_timeout", 32'(in_ready), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    if (in_ready && $countones(s) == 1) q[sel_idx(s)].push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = '0;
      exp_err = 1'b0;
    end else begin
      check("err_pulse", 32'(err_illegal_sel), 32'(exp_err));
      for (int k = 0; k < N; k++) begin
        if (stall[k]) begin
          check($sformatf("stall_valid%0d", k), 32'(out_valid[k]), 32'd1);
          check($sformatf("stall_data%0d", k), 32'(slot(k)), 32'(pd[k]));
        end
        if (out_valid[k] && out_ready[k]) begin
          if (q[k].size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL port%0d_extra: got %0h expected no beat", k, slot(k));
          end else check($sformatf("port%0d_data", k), 32'(slot(k)), 32'(q[k].pop_front()));
        end
        stall[k] = out_valid[k] & ~out_ready[k];
        pd[k] = slot(k);
      end
      if (in_valid && $countones(in_sel) != 1) check("illegal_ready", 32'(in_ready), 32'd1);
      exp_err = in_valid && $countones(in_sel) != 1;
    end
  end

  initial begin
    logic [N-1:0] ov;
    int r;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_err", 32'(err_illegal_sel), 32'd0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(in_ready), 32'd1);
    // async reset with slots full
    out_ready = '0;
    send(4'b0001, 8'h11);
    send(4'b0010, 8'h22);
    check("full_valid", 32'(out_valid), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", out_data, 32'd0);
    for (int k = 0; k < N; k++) q[k].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("ready_after_rst2", 32'(in_ready), 32'd1);
    // routing
    out_ready = '1;
    for (int k = 0; k < N; k++) begin
      send(N'(1 << k), 8'hA0 + 8'(k));
      check($sformatf("route_valid%0d", k), 32'(out_valid[k]), 32'd1);
      check($sformatf("route_data%0d", k), 32'(slot(k)), 32'hA0 + 32'(k));
    end
    // backpressure
    out_ready = 4'b1011;
    send(4'b0100, 8'h55);
    check("bp_data2", 32'(slot(2)), 32'h55);
    in_valid = 1'b1; in_sel = 4'b0100; in_data = 8'h77;
    @(negedge clk);
    check("bp_ready_blocked", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(4'b0001, 8'h66);
    check("bp_other_port", 32'(slot(0)), 32'h66);
    check("bp_held_valid", 32'(out_valid[2]), 32'd1);
    check("bp_held_data", 32'(slot(2)), 32'h55);
    out_ready = '1;
    send(4'b0100, 8'h77);
    check("bp_reload_valid", 32'(out_valid[2]), 32'd1);
    check("bp_reload_data", 32'(slot(2)), 32'h77);
    // illegal select
    out_ready = '0;
    ov = out_valid;
    send(4'b0000, 8'hEE);
    check("ill0_pulse", 32'(err_illegal_sel), 32'd1);
    send(4'b0110, 8'hEE);
    check("ill1_pulse", 32'(err_illegal_sel), 32'd1);
    check("ill_no_change", 32'(out_valid), 32'(ov));
    @(posedge clk); #1;
    check("ill_pulse_end", 32'(err_illegal_sel), 32'd0);
`ifdef DEMUX1HOT_ERR_CNT_EN
    check("err_cnt2", 32'(err_cnt), 32'd2);
`endif
    out_ready = '1;
`ifdef DEMUX1HOT_ERR_CNT_EN
    // saturation
    repeat (20) send(4'b0011, 8'hEE);
    check("err_cnt_sat", 32'(err_cnt), 32'd15);
    repeat (3) @(posedge clk);
    #1 check("err_cnt_hold", 32'(err_cnt), 32'd15);
    send(4'b1000, 8'h5A);
    check("sat_legal_data", 32'(slot(3)), 32'h5A);
`endif
    // random soak
    repeat (400) begin
      out_ready = N'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      in_sel = (r == 0) ? (($urandom_range(0, 1) != 0) ? 4'b0000 : 4'b0101) : N'(1 << $urandom_range(0, N - 1));
      in_data = W'($urandom);
      @(negedge clk);
      if (in_valid && in_ready && $countones(in_sel) == 1) q[sel_idx(in_sel)].push_back(in_data);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check($sformatf("drain_q%0d", k), 32'(q[k].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
